// File: rtl/mmio_pkg.sv
// Register map, bit positions and the masked-write helper shared by the
// data-memory MMIO responder and its TX FIFO.
package mmio_pkg;

   localparam logic [3:0] REG_MTIME_LO    = 4'd0;
   localparam logic [3:0] REG_MTIME_HI    = 4'd1;
   localparam logic [3:0] REG_MTIMECMP_LO = 4'd2;
   localparam logic [3:0] REG_MTIMECMP_HI = 4'd3;
   localparam logic [3:0] REG_CTRL        = 4'd4;
   localparam logic [3:0] REG_STATUS      = 4'd5;
   localparam logic [3:0] REG_TX_DATA     = 4'd6;

   localparam int CTRL_TIMER_EN = 0;
   localparam int CTRL_IRQ_EN   = 1;

   localparam int STAT_IRQ_PENDING = 0;
   localparam int STAT_FIFO_FULL   = 1;
   localparam int STAT_FIFO_EMPTY  = 2;
   localparam int STAT_OVERFLOW    = 3;
   localparam int STAT_COUNT_LSB   = 4;

   typedef enum logic [3:0] {
      MMIO_MTIME_LO    = REG_MTIME_LO,
      MMIO_MTIME_HI    = REG_MTIME_HI,
      MMIO_MTIMECMP_LO = REG_MTIMECMP_LO,
      MMIO_MTIMECMP_HI = REG_MTIMECMP_HI,
      MMIO_CTRL        = REG_CTRL,
      MMIO_STATUS      = REG_STATUS,
      MMIO_TX_DATA     = REG_TX_DATA
   } mmio_reg_e;

   // BWEB is active low: a 0 bit takes the new data, a 1 bit keeps the old.
   function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                                input logic [31:0] wr_data,
                                                input logic [31:0] bweb);
      return (old_val & bweb) | (wr_data & ~bweb);
   endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte FIFO feeding the console sink; head is presented straight from storage
// so a push into an empty FIFO becomes visible on the following cycle.
module mmio_tx_fifo
   import mmio_pkg::*;
#(
   parameter  int FIFO_DEPTH = 8,
   localparam int IDX_W      = $clog2(FIFO_DEPTH),
   localparam int PTR_W      = IDX_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [7:0]       push_data,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic [PTR_W-1:0] count,
   output logic             tx_valid,
   output logic [7:0]       tx_data,
   input  logic             tx_ready
);

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             pop;
   logic             push_ok;

   // Handshake: a byte leaves on every edge where tx_valid & tx_ready; while
   // tx_valid is high and tx_ready low, tx_data holds the same head byte.
   assign count    = wr_ptr - rd_ptr;
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (count == PTR_W'(FIFO_DEPTH));
   assign tx_valid = !empty;
   assign tx_data  = tx_valid ? mem[rd_ptr[IDX_W-1:0]] : 8'h00;
   assign pop      = tx_valid & tx_ready;
   // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
   assign push_ok  = push & (!full | pop);
   assign overflow = push & full & !pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[IDX_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/dm_mmio_responder.sv
// Data-memory-port peripheral: 64-bit machine timer with compare interrupt and
// a console TX FIFO, answering with SRAM-style timing (DO one cycle after read).
module dm_mmio_responder
   import mmio_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 14
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CEB,
   input  logic              WEB,
   input  logic [31:0]       BWEB,
   input  logic [ADDR_W-1:0] A,
   input  logic [31:0]       DI,
   output logic [31:0]       DO,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic              timer_irq
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [63:0]      mtime, mtime_nxt, mtimecmp;
   logic [31:0]      shadow_hi;
   logic             timer_en, irq_en, irq_pending, overflow;
   logic             pending_nxt, irq_en_nxt, timer_en_nxt, overflow_nxt;
   logic             mapped, rd_any, wr_en, irq_set;
   logic [3:0]       off;
   logic [31:0]      rd_data, stat_w1c, ctrl_new, cnt_ext;
   logic [3:0]       cnt_sat;
   logic             wr_lo, wr_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_stat, tx_push;
   logic             fifo_full, fifo_empty, fifo_ovf;
   logic [CNT_W-1:0] fifo_count;

   assign mapped = (A[ADDR_W-1:4] == '0);
   assign off    = A[3:0];
   assign rd_any = !CEB & WEB;
   assign wr_en  = !CEB & !WEB & mapped;

   assign wr_lo     = wr_en & (off == REG_MTIME_LO);
   assign wr_hi     = wr_en & (off == REG_MTIME_HI);
   assign wr_cmp_lo = wr_en & (off == REG_MTIMECMP_LO);
   assign wr_cmp_hi = wr_en & (off == REG_MTIMECMP_HI);
   assign wr_ctrl   = wr_en & (off == REG_CTRL);
   assign wr_stat   = wr_en & (off == REG_STATUS);
   assign tx_push   = wr_en & (off == REG_TX_DATA) & (BWEB[7:0] != 8'hFF);

   // A write to either mtime half suppresses the increment for the whole counter.
   always_comb begin
      mtime_nxt = mtime;
      if (wr_lo)         mtime_nxt[31:0]  = masked_write(mtime[31:0], DI, BWEB);
      else if (wr_hi)    mtime_nxt[63:32] = masked_write(mtime[63:32], DI, BWEB);
      else if (timer_en) mtime_nxt        = mtime + 64'd1;
   end

   assign irq_set      = timer_en & (mtime >= mtimecmp);
   assign stat_w1c     = wr_stat ? (DI & ~BWEB) : 32'h0;
   assign ctrl_new     = masked_write({30'h0, irq_en, timer_en}, DI, BWEB);
   assign timer_en_nxt = wr_ctrl ? ctrl_new[CTRL_TIMER_EN] : timer_en;
   assign irq_en_nxt   = wr_ctrl ? ctrl_new[CTRL_IRQ_EN] : irq_en;
   assign pending_nxt  = irq_set | (irq_pending & !stat_w1c[STAT_IRQ_PENDING]);
   assign overflow_nxt = fifo_ovf | (overflow & !stat_w1c[STAT_OVERFLOW]);

   assign cnt_ext = 32'(fifo_count);
   assign cnt_sat = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];

   always_comb begin
      rd_data = '0;
      if (mapped) begin
         case (off)
            MMIO_MTIME_LO:    rd_data = mtime[31:0];
            MMIO_MTIME_HI:    rd_data = shadow_hi;
            MMIO_MTIMECMP_LO: rd_data = mtimecmp[31:0];
            MMIO_MTIMECMP_HI: rd_data = mtimecmp[63:32];
            MMIO_CTRL: begin
               rd_data[CTRL_TIMER_EN] = timer_en;
               rd_data[CTRL_IRQ_EN]   = irq_en;
            end
            MMIO_STATUS: begin
               rd_data[STAT_IRQ_PENDING] = irq_pending;
               rd_data[STAT_FIFO_FULL]   = fifo_full;
               rd_data[STAT_FIFO_EMPTY]  = fifo_empty;
               rd_data[STAT_OVERFLOW]    = overflow;
               rd_data[STAT_COUNT_LSB+:4] = cnt_sat;
            end
            default:          rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         DO          <= '0;
         mtime       <= '0;
         mtimecmp    <= '1;
         shadow_hi   <= '0;
         timer_en    <= 1'b0;
         irq_en      <= 1'b0;
         irq_pending <= 1'b0;
         overflow    <= 1'b0;
         timer_irq   <= 1'b0;
      end else begin
         if (rd_any) DO <= rd_data;
         mtime <= mtime_nxt;
         if (wr_cmp_lo) mtimecmp[31:0]  <= masked_write(mtimecmp[31:0], DI, BWEB);
         if (wr_cmp_hi) mtimecmp[63:32] <= masked_write(mtimecmp[63:32], DI, BWEB);
         // The shadow follows a direct HI write so software reads back what it wrote.
         if (rd_any & mapped & (off == REG_MTIME_LO)) shadow_hi <= mtime[63:32];
         else if (wr_hi)                              shadow_hi <= mtime_nxt[63:32];
         timer_en    <= timer_en_nxt;
         irq_en      <= irq_en_nxt;
         irq_pending <= pending_nxt;
         overflow    <= overflow_nxt;
         timer_irq   <= pending_nxt & irq_en_nxt;
      end
   end

   mmio_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (tx_push),
      .push_data (DI[7:0] & ~BWEB[7:0]),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .overflow  (fifo_ovf),
      .count     (fifo_count),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready)
   );

endmodule

// File: tb/tb_dm_mmio_responder.sv
// Directed then randomized bench for dm_mmio_responder, every cycle compared
// against a register-level model of the timer, status bits and a byte queue.
module tb_dm_mmio_responder;

   localparam int DEPTH = 8;

   logic        CLK;
   logic        RST;
   logic        CEB;
   logic        WEB;
   logic [31:0] BWEB;
   logic [13:0] A;
   logic [31:0] DI;
   logic [31:0] DO;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        timer_irq;

   int n_tests = 0;
   int n_fail  = 0;

   dm_mmio_responder #(.FIFO_DEPTH(DEPTH), .ADDR_W(14)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .CEB       (CEB),
      .WEB       (WEB),
      .BWEB      (BWEB),
      .A         (A),
      .DI        (DI),
      .DO        (DO),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .timer_irq (timer_irq)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model state
   logic [63:0] m_mtime, m_cmp;
   logic [31:0] m_shadow, m_do;
   bit          m_ten, m_ien, m_pend, m_ovf, m_irq;
   logic [7:0]  m_q[$];

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [31:0] bw);
      return (o & bw) | (d & ~bw);
   endfunction

   function automatic logic [31:0] model_read(input logic [3:0] off);
      int cnt;
      cnt = (m_q.size() > 15) ? 15 : m_q.size();
      case (off)
         4'd0: return m_mtime[31:0];
         4'd1: return m_shadow;
         4'd2: return m_cmp[31:0];
         4'd3: return m_cmp[63:32];
         4'd4: return {30'h0, m_ien, m_ten};
         4'd5: return 32'(cnt) * 16 + (m_ovf ? 8 : 0) + ((m_q.size() == 0) ? 4 : 0)
                      + ((m_q.size() == DEPTH) ? 2 : 0) + (m_pend ? 1 : 0);
         default: return 32'h0;
      endcase
   endfunction

   function automatic void ref_step();
      bit          mapped, rd, wr, cond, pop, full, push, ovf_set;
      logic [3:0]  off;
      logic [31:0] mm, clr, ctl;
      if (RST) begin
         m_mtime = 64'h0; m_cmp = '1; m_shadow = 32'h0; m_do = 32'h0;
         m_ten = 0; m_ien = 0; m_pend = 0; m_ovf = 0; m_irq = 0;
         m_q.delete();
         return;
      end
      mapped  = (A[13:4] == 10'h0);
      off     = A[3:0];
      rd      = !CEB && WEB;
      wr      = !CEB && !WEB && mapped;
      mm      = ~BWEB;
      cond    = m_ten && (m_mtime >= m_cmp);
      pop     = (m_q.size() > 0) && tx_ready;
      full    = (m_q.size() == DEPTH);
      ovf_set = 0;
      if (rd) begin
         m_do = mapped ? model_read(off) : 32'h0;
         if (mapped && off == 4'd0) m_shadow = m_mtime[63:32];
      end
      clr = (wr && off == 4'd5) ? (DI & mm) : 32'h0;
      if (wr && off == 4'd0)      m_mtime[31:0] = merge(m_mtime[31:0], DI, BWEB);
      else if (wr && off == 4'd1) begin
         m_mtime[63:32] = merge(m_mtime[63:32], DI, BWEB);
         m_shadow = m_mtime[63:32];
      end
      else if (m_ten)             m_mtime = m_mtime + 1;
      if (wr && off == 4'd2) m_cmp[31:0]  = merge(m_cmp[31:0], DI, BWEB);
      if (wr && off == 4'd3) m_cmp[63:32] = merge(m_cmp[63:32], DI, BWEB);
      push = wr && off == 4'd6 && (mm[7:0] != 8'h0);
      if (pop) void'(m_q.pop_front());
      if (push) begin
         if (full && !pop) ovf_set = 1;
         else m_q.push_back(DI[7:0] & mm[7:0]);
      end
      m_pend = cond || (m_pend && !clr[0]);
      m_ovf  = ovf_set || (m_ovf && !clr[3]);
      if (wr && off == 4'd4) begin
         ctl   = merge({30'h0, m_ien, m_ten}, DI, BWEB);
         m_ten = ctl[0];
         m_ien = ctl[1];
      end
      m_irq = m_pend && m_ien;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      ref_step();
      #1;
      check("do", 64'(DO), 64'(m_do));
      check("tx_valid", 64'(tx_valid), 64'(m_q.size() > 0));
      check("tx_data", 64'(tx_data), 64'((m_q.size() > 0) ? m_q[0] : 8'h00));
      check("timer_irq", 64'(timer_irq), 64'(m_irq));
   endtask

   task automatic idle();
      CEB = 1'b1; WEB = 1'b1; BWEB = '1; A = '0; DI = '0;
      step();
   endtask

   task automatic wr(input logic [13:0] addr, input logic [31:0] d,
                     input logic [31:0] bw = 32'h0);
      CEB = 1'b0; WEB = 1'b0; A = addr; DI = d; BWEB = bw;
      step();
      CEB = 1'b1;
   endtask

   task automatic rd(input logic [13:0] addr);
      CEB = 1'b0; WEB = 1'b1; A = addr; DI = '0; BWEB = '1;
      step();
      CEB = 1'b1;
   endtask

   logic [31:0] exp_rst [8];

   initial begin
      exp_rst = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h4, 32'h0, 32'h0};
      RST = 1'b1; CEB = 1'b1; WEB = 1'b1; BWEB = '1; A = '0; DI = '0; tx_ready = 1'b0;
      step();
      step();
      RST = 1'b0;

      // Reset values of every offset, then an unmapped read
      for (int i = 0; i < 8; i++) begin
         rd(14'(i));
         check("rst_read", 64'(DO), 64'(exp_rst[i]));
      end
      rd(14'h010);
      check("unmapped_read", 64'(DO), 64'h0);

      // Compare interrupt at mtime == 20
      wr(14'd2, 32'd20);
      wr(14'd3, 32'd0);
      wr(14'd0, 32'd0);
      wr(14'd1, 32'd0);
      wr(14'd4, 32'd3);
      for (int i = 0; i < 20; i++) idle();
      check("irq_before_match", 64'(timer_irq), 64'h0);
      idle();
      check("irq_at_match", 64'(timer_irq), 64'h1);
      wr(14'd5, 32'h1);
      rd(14'd5);
      check("pend_set_wins", 64'(DO[0]), 64'h1);
      check("irq_held", 64'(timer_irq), 64'h1);

      // Byte-masked write to MTIME_LO with timer stopped
      wr(14'd4, 32'h0);
      wr(14'd0, 32'h0);
      wr(14'd0, 32'h0000_AB00, 32'hFFFF_00FF);
      rd(14'd0);
      check("mask_on_zero", 64'(DO), 64'h0000_AB00);
      wr(14'd0, 32'h1234_5678);
      wr(14'd0, 32'h0000_AB00, 32'hFFFF_00FF);
      rd(14'd0);
      check("mask_on_data", 64'(DO), 64'h1234_AB78);

      // Coherent LO/HI read across the 32-bit carry
      wr(14'd1, 32'h0);
      wr(14'd0, 32'hFFFF_FFFE);
      wr(14'd4, 32'h1);
      idle();
      rd(14'd0);
      check("coh_lo", 64'(DO), 64'hFFFF_FFFF);
      rd(14'd1);
      check("coh_hi_shadow", 64'(DO), 64'h0);
      rd(14'd0);
      check("coh_lo2", 64'(DO), 64'h1);
      rd(14'd1);
      check("coh_hi2", 64'(DO), 64'h1);
      wr(14'd4, 32'h0);
      wr(14'd5, 32'hF);

      // FIFO overflow then in-order drain
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) wr(14'd6, 32'h41 + 32'(i));
      rd(14'd5);
      check("stat_full_ovf", 64'(DO), 64'h8A);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("drain_valid", 64'(tx_valid), 64'h1);
         check("drain_data", 64'(tx_data), 64'h41 + 64'(i));
         idle();
      end
      check("drain_done", 64'(tx_valid), 64'h0);
      tx_ready = 1'b0;
      wr(14'd5, 32'h8);
      rd(14'd5);
      check("stat_empty", 64'(DO), 64'h04);

      // Push and pop together on a full FIFO
      for (int i = 0; i < 8; i++) wr(14'd6, 32'h50 + 32'(i));
      tx_ready = 1'b1;
      wr(14'd6, 32'h58);
      tx_ready = 1'b0;
      rd(14'd5);
      check("full_push_pop", 64'(DO), 64'h82);
      check("full_push_pop_head", 64'(tx_data), 64'h51);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) idle();
      check("drain2_done", 64'(tx_valid), 64'h0);
      tx_ready = 1'b0;

      // Reset while bytes are queued and the timer is interrupting
      for (int i = 0; i < 3; i++) wr(14'd6, 32'h61 + 32'(i));
      wr(14'd4, 32'h3);
      idle();
      idle();
      check("irq_before_rst", 64'(timer_irq), 64'h1);
      rd(14'd2);
      check("do_before_rst", 64'(DO), 64'd20);
      RST = 1'b1;
      idle();
      RST = 1'b0;
      check("rst_tx_valid", 64'(tx_valid), 64'h0);
      check("rst_irq", 64'(timer_irq), 64'h0);
      check("rst_do", 64'(DO), 64'h0);
      rd(14'd0);
      check("rst_mtime", 64'(DO), 64'h0);
      rd(14'd4);
      check("rst_ctrl", 64'(DO), 64'h0);

      // Randomized accesses against the model
      for (int n = 0; n < 800; n++) begin
         RST      = ($urandom_range(0, 199) == 0);
         tx_ready = 1'($urandom_range(0, 1));
         CEB      = ($urandom_range(0, 3) == 0);
         WEB      = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) A = 14'($urandom);
         else                           A = 14'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       BWEB = 32'h0;
            1:       BWEB = 32'hFFFF_FFFF;
            2:       BWEB = $urandom;
            default: BWEB = 32'hFFFF_FF00;
         endcase
         DI = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         step();
      end
      RST = 1'b0;
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dm_mmio_responder.md
# dm_mmio_responder

Memory-mapped peripheral that answers the CPU data-memory port with the same request/response protocol as the SRAM wrapper: active-low chip enable, active-low write and per-bit write masks, a 14-bit word address, and read data registered one cycle after the request. It provides a 64-bit machine timer with compare interrupt and an 8-entry transmit FIFO drained by a valid/ready console sink. It sits beside DM1 and is selected by top-level address decode.

## Interface
- `FIFO_DEPTH`, default 8, TX FIFO entries (power of two, ≥2).
- `ADDR_W`, default 14, word-address width.
- `CLK` input 1 — single clock; all state updates on rising edge.
- `RST` input 1 — synchronous, active-high reset.
- `CEB` input 1 — chip enable, active low; no access when 1.
- `WEB` input 1 — 0 = write, 1 = read (qualified by CEB=0).
- `BWEB` input 32 — per-bit write mask, active low (bit i written when BWEB[i]=0).
- `A` input ADDR_W — word address.
- `DI` input 32 — write data.
- `DO` output 32 — registered read data.
- `tx_valid` output 1 — FIFO head valid toward console sink.
- `tx_data` output 8 — FIFO head byte.
- `tx_ready` input 1 — sink accepts head when tx_valid & tx_ready.
- `timer_irq` output 1 — level interrupt = irq_pending & CTRL.irq_en.

## Operation
- Decode: A[ADDR_W-1:4] must be 0, else unmapped. Register at A[3:0]:
  - 0 MTIME_LO (RW), 1 MTIME_HI (RW), 2 MTIMECMP_LO (RW), 3 MTIMECMP_HI (RW)
  - 4 CTRL (RW): bit0 timer_en, bit1 irq_en; others read 0
  - 5 STATUS: bit0 irq_pending (W1C), bit1 fifo_full, bit2 fifo_empty, bit3 overflow (sticky, W1C), bits[7:4] fifo count (saturates at 15); others 0
  - 6 TX_DATA (WO): write pushes masked DI[7:0]; reads 0
- Writes: new = (old & ~M) | (DI & M) with M = ~BWEB. TX push occurs when any of BWEB[7:0] is 0.
- Unmapped reads return 0; unmapped writes are ignored.
- mtime increments by 1 each cycle when timer_en=1; wraps 2^64-1 → 0.
- Write to MTIME_LO/HI in the same cycle as increment: write wins for the written half; the other half is not incremented that cycle.
- irq_pending sets when timer_en=1 and mtime ≥ mtimecmp (unsigned 64-bit, registered values). Set wins over simultaneous W1C.
- Coherent read: a read of MTIME_LO latches mtime[63:32] into a shadow register; the next MTIME_HI read returns the shadow until MTIME_LO is read again.
- FIFO push when full: data dropped, overflow=1. Push and pop in the same cycle on a full FIFO: both occur, count unchanged, no overflow. Push into an empty FIFO: tx_valid rises the next cycle (no bypass).

## Timing
- Read: A sampled on the edge where CEB=0 & WEB=1; DO valid after that edge; held until the next read edge. Writes and idle cycles do not change DO.
- Read-after-write to the same register in consecutive cycles returns the new value.
- MTIME reads return the value at the sampling edge, before that edge's increment.
- timer_irq is registered; it asserts 1 cycle after the compare condition first holds.
- tx_data/tx_valid are FIFO-head registers; pop on tx_valid & tx_ready; tx_data is stable while tx_valid & !tx_ready.
- Reset values: DO=0, tx_valid=0, tx_data=0, timer_irq=0, mtime=0, mtimecmp=all ones, CTRL=0, STATUS flags 0, FIFO empty, shadow=0. Reset mid-transfer discards FIFO contents and any in-flight access.

## Structure
- Package `mmio_pkg`: register offset localparams (REG_MTIME_LO … REG_TX_DATA), CTRL/STATUS bit-index constants, and a `mmio_reg_e` enum.
- Sub-module `mmio_tx_fifo` (FIFO_DEPTH, 8-bit data): push/full/overflow, valid/ready head, count output. Pointers are log2(FIFO_DEPTH)+1 bits.

## Test plan
- Reset, then read all offsets 0–7 → DO = 0,0,FFFF_FFFF,FFFF_FFFF,0,0x4 (empty),0,0 in successive cycles; unmapped A=0x010 → 0.
- Write MTIMECMP_LO=20, HI=0, CTRL=3, mtime=0 → timer_irq rises exactly 1 cycle after mtime reaches 20; W1C STATUS bit0 while still ≥ → pending remains 1.
- Write MTIME_LO with BWEB=FFFF_00FF, DI=0x0000_AB00 and timer_en=0 → readback 0x0000_AB00; other bytes unchanged.
- Coherent read: mtime=0x0000_0000_FFFF_FFFF running; read LO then HI next cycle → HI=0 (shadow), mtime has rolled to HI=1.
- tx_ready=0; push 9 bytes 0x41..0x49 → STATUS full=1, overflow=1, count=8; raise tx_ready → 0x41..0x48 drained in order, one per cycle, tx_valid drops after last.
- Assert RST with 3 bytes queued and timer running → next cycle tx_valid=0, mtime=0, DO=0, timer_irq=0.
